// File: rtl/fp_normalize_round.sv
// fp_normalize_round
//   Normalizes and rounds a raw sign/exponent/mantissa triple to an IEEE-754
//   single-precision value. The mantissa is shifted one bit per cycle until its
//   leading one sits at weight 2^0, then rounded to nearest, ties to even.
//   Results that are too large saturate to infinity. Results that are too small
//   flush to signed zero, because subnormals are not produced.
//   Only one operation is in flight at a time.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   raw operand presented
//   in_ready   block idle and able to accept an operand
//   in_sign    result sign
//   in_exp     10-bit two's-complement biased exponent (bias 127)
//   in_man     MAN_W-bit unnormalized magnitude; bit MAN_W-2 has weight 2^0
//   out_valid  out_result and flags valid
//   out_ready  consumer takes the result
//   out_result IEEE-754 single result
//   out_ovf    overflow to infinity occurred
//   out_unf    underflow to zero occurred
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// SHIFT | one normalization shift per cycle
// ROUND | round, range check, and register the result
// DONE  | result held until out_ready

module fp_normalize_round #(
  parameter int MAN_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [9:0]       in_exp,
  input  logic [MAN_W-1:0] in_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_ovf,
  output logic             out_unf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]         state;
  logic               sign_q;
  logic [MAN_W-1:0]   man_q;
  logic signed [10:0] exp_q;
  logic               sticky_q;

  logic [22:0]        frac;
  logic               guard;
  logic               sticky_all;
  logic               round_up;
  logic               carry;
  logic [22:0]        frac_rnd;
  logic signed [10:0] exp_rnd;

  assign in_ready = (state == IDLE);

  // The fraction lies just below the leading one. The guard bit lies below
  // the fraction. Everything lower, plus any bits shifted out to the right,
  // folds into the sticky bit.
  always_comb begin
    frac       = man_q[MAN_W-3 -: 23];
    guard      = man_q[MAN_W-26];
    sticky_all = (|man_q[MAN_W-27:0]) | sticky_q;
    round_up   = guard & (sticky_all | frac[0]);
    // When an all-ones fraction is rounded up, the incremented fraction wraps
    // to zero. That is the correct fraction after the carry, so only the
    // exponent needs adjusting.
    carry      = round_up & (&frac);
    frac_rnd   = frac + 23'(round_up);
    exp_rnd    = exp_q + $signed({10'b0, carry});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sign_q     <= 1'b0;
      man_q      <= '0;
      exp_q      <= '0;
      sticky_q   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_unf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= in_sign;
            man_q    <= in_man;
            exp_q    <= {in_exp[9], in_exp};
            sticky_q <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (man_q == '0) begin
            out_result <= {sign_q, 31'b0};
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else if (man_q[MAN_W-1]) begin
            man_q    <= man_q >> 1;
            sticky_q <= sticky_q | man_q[0];
            exp_q    <= exp_q + 11'sd1;
          end else if (!man_q[MAN_W-2]) begin
            man_q <= man_q << 1;
            exp_q <= exp_q - 11'sd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          out_valid <= 1'b1;
          state     <= DONE;
          if (exp_rnd >= 11'sd255) begin
            out_result <= {sign_q, 8'hFF, 23'b0};
            out_ovf    <= 1'b1;
            out_unf    <= 1'b0;
          end else if (exp_rnd <= 11'sd0) begin
            out_result <= {sign_q, 31'b0};
            out_ovf    <= 1'b0;
            out_unf    <= 1'b1;
          end else begin
            out_result <= {sign_q, exp_rnd[7:0], frac_rnd};
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// tb_fp_normalize_round
//   Directed vectors with hand-computed results. The driver pushes the expected
//   result, flags and latency into a queue. The monitor pops and compares the
//   queued entry on the first cycle of each out_valid pulse.

module tb_fp_normalize_round;

  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        unf;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_man = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_ovf;
  logic        out_unf;

  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  exp_t sb_q[$];

  fp_normalize_round #(.MAN_W(48)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  // monitor
  logic seen = 1'b0;
  always @(negedge clk) begin
    if (!out_valid) seen = 1'b0;
    else if (!seen) begin
      seen = 1'b1;
      if (sb_q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", out_result, e.result);
        chk("ovf", {31'b0, out_ovf}, {31'b0, e.ovf});
        chk("unf", {31'b0, out_unf}, {31'b0, e.unf});
        chk("latency", cyc - e.acc, e.lat);
      end
    end
    if (out_valid && out_ready) seen = 1'b0;
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 200 && !in_ready; i++) @(posedge clk) #1;
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk) #1;
    chk("drain", sb_q.size(), 32'd0);
  endtask

  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                      input logic [31:0] r, input logic ovf, input logic unf,
                      input int lat, input bit expect_out);
    exp_t x;
    wait_ready();
    in_valid = 1'b1; in_sign = s; in_exp = e; in_man = m;
    @(posedge clk) #1;
    in_valid = 1'b0;
    x.result = r; x.ovf = ovf; x.unf = unf; x.lat = lat; x.acc = cyc;
    if (expect_out) sb_q.push_back(x);
  endtask

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_flags", {30'b0, out_ovf, out_unf}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk) #1;

    send(0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 0, 0, 2, 1);  drain();
    send(0, 10'd127, 48'h8000_0000_0000, 32'h4000_0000, 0, 0, 3, 1);  drain();
    send(0, 10'd173, 48'h0000_0000_0001, 32'h3F80_0000, 0, 0, 48, 1); drain();
    send(0, 10'd127, 48'h4000_0040_0000, 32'h3F80_0000, 0, 0, 2, 1);  drain();
    send(0, 10'd127, 48'h4000_00C0_0000, 32'h3F80_0002, 0, 0, 2, 1);  drain();
    send(0, 10'd254, 48'h7FFF_FFFF_FFFF, 32'h7F80_0000, 1, 0, 2, 1);  drain();
    send(1, 10'd0,   48'h4000_0000_0000, 32'h8000_0000, 0, 1, 2, 1);  drain();
    send(1, 10'd100, 48'h0000_0000_0000, 32'h8000_0000, 0, 0, 1, 1);  drain();
    // a bit shifted out on the right must force a round up at a tie
    send(0, 10'd127, 48'h8000_0080_0001, 32'h4000_0001, 0, 0, 3, 1);  drain();
    // in_exp = -1 must be sign-extended; the carry then brings it to 0
    send(0, 10'h3FF, 48'h8000_0000_0000, 32'h0000_0000, 0, 1, 3, 1);  drain();
    send(0, 10'd254, 48'h4000_0000_0000, 32'h7F00_0000, 0, 0, 2, 1);  drain();
    send(0, 10'd1,   48'h4000_0000_0000, 32'h0080_0000, 0, 0, 2, 1);  drain();
    send(0, 10'd2,   48'h1000_0000_0000, 32'h0000_0000, 0, 1, 4, 1);  drain();

    // hold the result while out_ready is low
    out_ready = 1'b0;
    send(0, 10'd128, 48'h6000_0000_0000, 32'h4040_0000, 0, 0, 2, 1);
    for (int i = 0; i < 20 && !out_valid; i++) @(posedge clk) #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk) #1;
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", out_result, 32'h4040_0000);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    drain();

    // reset in the middle of SHIFT; in_valid held high across the reset edge
    send(0, 10'd173, 48'h0000_0000_0001, 32'h0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b1;
    @(posedge clk) #1;
    rst_n = 1'b1; in_valid = 1'b0;
    chk("midshift_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midshift_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk) #1;
    chk("no_capture_in_reset", {31'b0, in_ready}, 32'd1);
    repeat (60) @(posedge clk);
    #1;
    chk("no_stale_out_valid", {31'b0, out_valid}, 32'd0);

    // the block must still work after the aborted operation
    send(0, 10'd127, 48'h4000_0000_0000, 32'h3F80_0000, 0, 0, 2, 1); drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 SHALL have parameter MAN_W, default 48, meaning raw mantissa width; bit MAN_W-2 carries weight 2^0.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset is synchronous and active-low, sampled on the clk rising edge.
REQ-004 SHALL have port in_valid, input, 1, meaning a raw operand is presented.
REQ-005 SHALL have port in_ready, output, 1, meaning the block can accept an operand.
REQ-006 SHALL have port in_sign, input, 1, meaning the result sign.
REQ-007 SHALL have port in_exp, input, 10, meaning the two's-complement biased exponent (bias 127) of in_man.
REQ-008 SHALL have port in_man, input, MAN_W, meaning the unnormalized magnitude, format 2.46.
REQ-009 SHALL have port out_valid, output, 1, meaning out_result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port out_result, output, 32, meaning the IEEE-754 single result.
REQ-012 SHALL have ports out_ovf and out_unf, output, 1 each, meaning overflow-to-infinity and underflow-to-zero occurred.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, ROUND, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE.
REQ-015 IDLE: in_valid=1 at an edge SHALL capture sign, in_man, and in_exp sign-extended to an 11-bit internal exponent, then go to SHIFT.
REQ-016 SHIFT, man==0: SHALL go to DONE with result {sign,31'b0}, flags 0.
REQ-017 SHIFT, man[47]=1: SHALL shift man right 1, OR the dropped bit into a sticky register, exp+1, and stay in SHIFT.
REQ-018 SHIFT, man[47:46]=00: SHALL shift man left 1, exp-1, and stay in SHIFT.
REQ-019 SHIFT, man[47:46]=01: SHALL go to ROUND.
REQ-020 ROUND: fraction=man[45:23], guard=man[22], S=|man[21:0]|sticky; round up iff guard & (S | man[23]) (round to nearest, ties to even).
REQ-021 A rounding carry out of {1,fraction} SHALL set fraction=0 and exp+1.
REQ-022 After rounding, exp>=255 SHALL give {sign,8'hFF,23'b0} with out_ovf=1.
REQ-023 After rounding, exp<=0 SHALL give {sign,31'b0} with out_unf=1; there are no subnormals.
REQ-024 Otherwise the result SHALL be {sign,exp[7:0],fraction}; ROUND then goes to DONE.
REQ-025 DONE: SHALL hold out_valid=1 and out_result/flags stable until out_ready=1 at an edge, then go to IDLE.
REQ-026 Latency SHALL be: accept at edge N, out_valid high from edge N+2+s, where s = number of SHIFT shift cycles; zero operand from edge N+1.
REQ-027 Throughput SHALL be one operation in flight; a new accept is possible no earlier than the edge after the out handshake.
REQ-028 out_valid SHALL be 0 in all states except DONE.
REQ-029 out_result and flags SHALL be registered and change only on entry to DONE or on reset.

Reset
REQ-030 rst_n=0 at an edge SHALL set state IDLE, out_valid=0, out_result=0, out_ovf=0, out_unf=0, sticky=0, and internal mantissa and exponent to 0.
REQ-031 Reset in any state, including mid-SHIFT or DONE, SHALL discard the in-flight operation, with in_ready=1 in the following cycle.
REQ-032 No capture SHALL occur at an edge where rst_n=0, regardless of in_valid.

Verification
REQ-033 Normalized: sign 0, exp 127, man 48'h4000_0000_0000 SHALL give 32'h3F80_0000 at edge N+2, flags 0.
REQ-034 Carry input: exp 127, man 48'h8000_0000_0000 SHALL give 32'h4000_0000 at edge N+3.
REQ-035 Leading zeros: exp 173, man 48'h0000_0000_0001 SHALL give 46 shifts, 32'h3F80_0000 at edge N+48.
REQ-036 RNE: man 48'h4000_0040_0000 (tie, lsb 0) SHALL give 32'h3F80_0000; man 48'h4000_00C0_0000 (tie, lsb 1) SHALL give 32'h3F80_0002.
REQ-037 Range: exp 254, man 48'h7FFF_FFFF_FFFF SHALL give 32'h7F80_0000 with ovf=1; exp 0, man 48'h4000_0000_0000, sign 1 SHALL give 32'h8000_0000 with unf=1.
REQ-038 Control: out_ready=0 for 5 cycles SHALL hold result and out_valid stable with in_ready=0; rst_n=0 mid-SHIFT SHALL give out_valid=0 and in_ready=1 the next cycle.
